// File: rtl/kv_sort_pkg.sv
// Shared types and helpers for the key/value odd-even transposition sorter.
// Lane extraction works on a zero-extended bus, so callers must truncate to their width.
package kv_sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Phase parity: even phases pair (0,1),(2,3)..; odd phases pair (1,2),(3,4)..
    localparam logic PH_EVEN = 1'b0;
    localparam logic PH_ODD  = 1'b1;

    localparam int BUS_MAX_W  = 4096;
    localparam int LANE_MAX_W = 64;

    function automatic logic [LANE_MAX_W-1:0] lane_key(input logic [BUS_MAX_W-1:0] bus,
                                                       input int i, input int kw);
        return LANE_MAX_W'(bus >> (i * kw));
    endfunction

    function automatic logic [LANE_MAX_W-1:0] lane_val(input logic [BUS_MAX_W-1:0] bus,
                                                       input int i, input int vw);
        return LANE_MAX_W'(bus >> (i * vw));
    endfunction

endpackage

// File: rtl/kv_cmp_swap.sv
// One compare-exchange cell. Equal keys never swap, which keeps the sort stable.
module kv_cmp_swap #(
    parameter int KW = 8,
    parameter int VW = 8
) (
    input  logic [KW-1:0] i_a_key,
    input  logic [KW-1:0] i_b_key,
    input  logic [VW-1:0] i_a_val,
    input  logic [VW-1:0] i_b_val,
    input  logic          i_desc,
    input  logic          i_en,
    output logic [KW-1:0] o_a_key,
    output logic [KW-1:0] o_b_key,
    output logic [VW-1:0] o_a_val,
    output logic [VW-1:0] o_b_val,
    output logic          o_swapped
);

    logic w_out_of_order;

    assign w_out_of_order = i_desc ? (i_a_key < i_b_key) : (i_a_key > i_b_key);
    assign o_swapped      = i_en && w_out_of_order;

    assign o_a_key = o_swapped ? i_b_key : i_a_key;
    assign o_b_key = o_swapped ? i_a_key : i_b_key;
    assign o_a_val = o_swapped ? i_b_val : i_a_val;
    assign o_b_val = o_swapped ? i_a_val : i_b_val;

endmodule

// File: rtl/kv_sort_seq.sv
// Sequential key/value sorter: one odd-even transposition phase per clock,
// valid/ready on both sides, optional exit after two consecutive quiet phases.
module kv_sort_seq
    import kv_sort_pkg::*;
#(
    parameter int N          = 16,
    parameter int KW         = 8,
    parameter int VW         = 8,
    parameter int EARLY_EXIT = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_desc,
    input  logic [N*KW-1:0]          in_keys,
    input  logic [N*VW-1:0]          in_vals,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N*KW-1:0]          out_keys,
    output logic [N*VW-1:0]          out_vals,
    output logic                     busy,
    output logic [$clog2(N+1)-1:0]   phases_used
);

    localparam int             PW      = $clog2(N + 1);
    localparam logic [PW-1:0]  LAST_PH = PW'(N - 1);

    state_e                 r_state, w_state_nxt;
    logic [N-1:0][KW-1:0]   r_keys, w_in_keys, w_nxt_keys;
    logic [N-1:0][VW-1:0]   r_vals, w_in_vals, w_nxt_vals;
    logic                   r_desc;
    logic                   r_quiet;
    logic [PW-1:0]          r_phase;
    logic [PW-1:0]          r_phases_used;

    logic [N-2:0][KW-1:0]   w_a_key, w_b_key;
    logic [N-2:0][VW-1:0]   w_a_val, w_b_val;
    logic [N-2:0]           w_sw;
    logic                   w_swapped, w_sorting, w_accept, w_exit;

    assign w_sorting = (r_state == SORT);
    assign w_accept  = in_valid && in_ready;
    assign w_swapped = |w_sw;
    // r_quiet remembers that the previous phase was quiet; one quiet phase alone proves nothing
    assign w_exit    = w_sorting &&
                       ((r_phase == LAST_PH) || ((EARLY_EXIT != 0) && !w_swapped && r_quiet));

    for (genvar j = 0; j < N; j++) begin : g_unpack
        assign w_in_keys[j] = KW'(lane_key(BUS_MAX_W'(in_keys), j, KW));
        assign w_in_vals[j] = VW'(lane_val(BUS_MAX_W'(in_vals), j, VW));
    end

    for (genvar gi = 0; gi < N - 1; gi++) begin : g_cs
        localparam logic PAR = (gi % 2 == 0) ? PH_EVEN : PH_ODD;
        kv_cmp_swap #(.KW(KW), .VW(VW)) u_cs (
            .i_a_key   (r_keys[gi]),
            .i_b_key   (r_keys[gi+1]),
            .i_a_val   (r_vals[gi]),
            .i_b_val   (r_vals[gi+1]),
            .i_desc    (r_desc),
            .i_en      (w_sorting && (r_phase[0] == PAR)),
            .o_a_key   (w_a_key[gi]),
            .o_b_key   (w_b_key[gi]),
            .o_a_val   (w_a_val[gi]),
            .o_b_val   (w_b_val[gi]),
            .o_swapped (w_sw[gi])
        );
    end

    // A lane is the 'a' side of the active pair when its parity matches the phase, else the 'b' side
    for (genvar gj = 0; gj < N; gj++) begin : g_lane
        localparam logic LP = (gj % 2 == 0) ? PH_EVEN : PH_ODD;
        if (gj == 0) begin : g_first
            assign w_nxt_keys[gj] = (r_phase[0] == PH_EVEN) ? w_a_key[gj] : r_keys[gj];
            assign w_nxt_vals[gj] = (r_phase[0] == PH_EVEN) ? w_a_val[gj] : r_vals[gj];
        end else if (gj == N - 1) begin : g_last
            assign w_nxt_keys[gj] = (r_phase[0] == PH_EVEN) ? w_b_key[gj-1] : r_keys[gj];
            assign w_nxt_vals[gj] = (r_phase[0] == PH_EVEN) ? w_b_val[gj-1] : r_vals[gj];
        end else begin : g_mid
            assign w_nxt_keys[gj] = (r_phase[0] == LP) ? w_a_key[gj] : w_b_key[gj-1];
            assign w_nxt_vals[gj] = (r_phase[0] == LP) ? w_a_val[gj] : w_b_val[gj-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = SORT;
            SORT:    if (w_exit)   w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = in_valid ? SORT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
        out_valid = (r_state == DONE);
        busy      = (r_state == SORT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keys        <= '0;
            r_vals        <= '0;
            r_desc        <= 1'b0;
            r_quiet       <= 1'b0;
            r_phase       <= '0;
            r_phases_used <= '0;
        end else if (w_accept) begin
            r_keys  <= w_in_keys;
            r_vals  <= w_in_vals;
            r_desc  <= in_desc;
            r_quiet <= 1'b0;
            r_phase <= '0;
        end else if (w_sorting) begin
            r_keys  <= w_nxt_keys;
            r_vals  <= w_nxt_vals;
            r_quiet <= !w_swapped;
            r_phase <= r_phase + PW'(1);
            if (w_exit) r_phases_used <= r_phase + PW'(1);
        end
    end

    assign out_keys    = r_keys;
    assign out_vals    = r_vals;
    assign phases_used = r_phases_used;

endmodule

// File: doc/kv_sort_seq.md
# kv_sort_seq

Parametrised, sequential key/value sorter for the similarity-search datapath. Accepts N (key, value) pairs in one parallel beat and sorts them by key with an odd-even transposition network that runs one compare-exchange phase per clock. Returns the sorted pairs with a valid/ready handshake. Keys are Hamming distances; values are candidate IDs. The block sits between the distance-compute stage and the top-K result buffer.

## Interface
- N, 16, number of pairs; even, ≥2
- KW, 8, key width in bits
- VW, 8, value width in bits
- EARLY_EXIT, 0, when 1, stop sorting after two consecutive phases with no swap
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_desc  in  1  sort order for this beat: 0 = ascending, 1 = descending
- in_keys  in  N*KW  lane i at bits [i*KW +: KW]
- in_vals  in  N*VW  lane i at bits [i*VW +: VW]
- out_valid  out  1  sorted result held
- out_ready  in  1  consumer takes the result
- out_keys  out  N*KW  sorted keys; lane 0 is the first in order
- out_vals  out  N*VW  values travelling with their keys
- busy  out  1  high in SORT
- phases_used  out  $clog2(N+1)  number of phases run for the held result

## Operation
- FSM has three states: IDLE, SORT, DONE.
- IDLE: in_ready=1. On in_valid:
  - load all lanes
  - latch in_desc
  - clear the phase counter and no-swap counter
  - go to SORT
- SORT: each cycle runs one phase.
  - Even phase counts compare pairs (0,1),(2,3),…,(N-2,N-1).
  - Odd phase counts compare pairs (1,2),…,(N-3,N-2).
- Compare rule:
  - Ascending: swap when key[i] > key[i+1], strictly.
  - Descending: swap when key[i] < key[i+1], strictly.
  - Equal keys never swap, so the sort is stable.
  - The value always moves with its key.
- Keys compare as unsigned.
- Exit to DONE:
  - after phase N-1 (N phases total), or
  - with EARLY_EXIT=1, after a phase with no swap that directly follows another phase with no swap.
- The two-phase early-exit rule is required. A single quiet phase does not prove the data is sorted.
- phases_used is written on exit.
- DONE: out_valid=1 and the registers are frozen.
  - If out_ready=1, the result is consumed.
  - If in_valid=1 in the same cycle, the new beat loads and the state goes to SORT (back-to-back).
  - Otherwise the state goes to IDLE.
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- in_valid in SORT is ignored (in_ready=0). in_valid is not queued.
- out_keys/out_vals always show the lane registers. They hold meaningful data only while out_valid=1.

## Timing
- Reset values: state=IDLE, out_valid=0, busy=0, phases_used=0, and all lane registers are 0. in_ready is 0 while rst=1 and 1 on the first cycle after rst falls.
- Accept edge A: data loads. Phases run on edges A+1 … A+N.
- out_valid is high from the cycle after edge A+N. Latency is N cycles, fixed when EARLY_EXIT=0.
- With EARLY_EXIT=1, the minimum latency is 2 cycles (already-sorted input).
- Throughput, back-to-back: one result every N+1 cycles when out_ready is held high.
- rst asserted in SORT or DONE: the result is dropped and all outputs are cleared on that edge.
- Stall: out_valid, out_keys and out_vals stay stable until the out_valid && out_ready edge.

## Structure
- Package kv_sort_pkg holds:
  - the state enum (IDLE/SORT/DONE)
  - the function lane_key(bus, i) and the function lane_val(bus, i)
  - the phase-parity constant names
- Sub-module kv_cmp_swap, one instance per compare pair:
  - parameters KW, VW
  - inputs: a/b keys and values, desc, en
  - outputs: the swapped pair and a swapped flag
  - combinational
- The top level owns the registers, the FSM, the counters and the OR-reduction of the swapped flags.
- Target size is about 200 lines of RTL.

## Test plan
- Reset check, N=16, ascending. Apply rst for 2 cycles with in_valid=1 → in_ready=0 and out_valid=0 during rst, all outputs 0.
- Reverse ordered input, N=16. Keys 15..0, vals = key+100, asc → out_valid exactly 16 cycles after accept. Keys 0..15 with vals 100..115. phases_used=16.
- Duplicates, stability. Keys {5,3,5,3,…} with vals = lane index, asc → all 3s first, then the 5s. Within equal keys, vals are in increasing lane order.
- Descending mode plus back-to-back. Beat 1 is keys 0..15 desc, beat 2 is presented in the DONE cycle with out_ready=1 → beat 2 accepted on the same edge. Result 1 is keys 15..0. Result 2 is valid N+1 cycles after result 1.
- EARLY_EXIT=1, sorted input. Keys 0..15 asc → out_valid after 2 cycles, phases_used=2, output equals input.
- Backpressure and mid-sort reset. Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Next beat: assert rst at phase 7 → following cycle has state IDLE, out_valid=0, keys 0.
